alu_seq_ctrl: RTL and testbench
===============================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-high.
REQ-002 clk  in  1  system clock, all state updates on rising edge.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 in_valid  in  1  instruction offered.
REQ-005 in_ready  out  1  controller can accept; high only in IDLE.
REQ-006 in_op  in  4  opcode, OP_* codes of the shared ALU constants header.
REQ-007 in_rd, in_ra, in_rb  in  2 each  destination, source A, source B register indices.
REQ-008 in_use_imm  in  1  when 1, operand B = in_imm instead of register rb.
REQ-009 in_imm  in  4  immediate operand.
REQ-010 out_valid  out  1  result available; held until accepted.
REQ-011 out_ready  in  1  consumer accepts result.
REQ-012 out_result  out  4  value written to rd.
REQ-013 out_zero, out_carry, out_overflow, out_error  out  1 each  flags of the completed instruction.
REQ-014 err_count  out  8  saturating count of completed instructions with out_error=1.

Function
REQ-015 SHALL hold register file R0..R3 (4 bits each); R0 always reads 0; writes to R0 are discarded.
REQ-016 SHALL hold internal HI and LO registers (4 bits each).
REQ-017 FSM states SHALL be IDLE, EXEC, RESP; reset state IDLE.
REQ-018 IDLE: in_valid&&in_ready SHALL latch op, rd, operand A = R[ra], operand B = (use_imm ? imm : R[rb]) and go to EXEC.
REQ-019 EXEC for every op except OP_MULT, OP_MFHI, OP_MFLO SHALL last exactly 1 cycle, using one instance of the team ALU (combinational) on the latched operands, then go to RESP.
REQ-020 OP_MULT SHALL be a 4-cycle shift-add over latched operands (one multiplier bit per cycle, LSB first) producing an 8-bit product; on completion LO = product[3:0], HI = product[7:4], result = product[3:0].
REQ-021 OP_MULT flags: zero = (product == 0), carry = 0, overflow = 0, error = 0.
REQ-022 OP_MFHI / OP_MFLO SHALL take 1 EXEC cycle, result = HI / LO, zero = (result == 0), other flags 0; the ALU instance's MFHI/MFLO outputs SHALL NOT be used.
REQ-023 On EXEC->RESP the result SHALL be written to R[rd] and out_result/flags registered; any instruction with error=1 (divide by zero, rotate amount >3) SHALL still write its ALU output (0 or unrotated A).
REQ-024 Latency: accept edge N -> out_valid high after edge N+2 (single-cycle ops) or N+5 (OP_MULT).
REQ-025 RESP: out_valid=1, outputs stable until out_valid&&out_ready; then IDLE on that edge; no new instruction accepted in the same cycle.
REQ-026 in_valid while in_ready=0 SHALL be ignored; no queuing.
REQ-027 A register written by instruction K SHALL be visible as a source to instruction K+1.
REQ-028 err_count SHALL increment by 1 on each RESP entry with error=1, saturating at 255.
REQ-029 HI/LO SHALL change only on OP_MULT completion.

Reset
REQ-030 rst=1 SHALL immediately force: state IDLE, R1..R3=0, HI=LO=0, out_valid=0, out_result=0, all flags 0, err_count=0; in_ready=1 once rst deasserts.
REQ-031 rst asserted during EXEC or RESP SHALL abort the instruction with no register, HI/LO, or err_count update.

Verification
REQ-032 OP_ADD rd=1 ra=0 imm=7; then OP_ADD rd=2 ra=1 imm=10 -> R1=7; out_result=1, carry=1, overflow=0, zero=0; each out_valid 2 cycles after accept.
REQ-033 OP_MULT ra=R1(7) imm=9 -> out_valid 5 cycles after accept, out_result=0xF, LO=0xF; then OP_MFHI rd=3 -> out_result=0x3, R3=3.
REQ-034 OP_DIVIDE ra=R1 imm=0 -> out_result=0, error=1, zero=1, err_count=1; 256 such ops -> err_count stays 255.
REQ-035 out_ready held 0 for 10 cycles in RESP while in_valid=1 -> outputs stable, in_ready=0, no second instruction accepted; out_ready=1 -> IDLE next edge.
REQ-036 rst pulsed in 3rd cycle of OP_MULT -> out_valid never asserted for it, HI=LO=0, rd unchanged, in_ready=1 after release.
REQ-037 OP_ADD rd=0 ra=0 imm=5 -> out_result=5, subsequent read of R0 returns 0.

Source files
------------

// File: rtl/alu_seq_ctrl_if.sv
// Instruction/result handshake bundle between an issuing master and the
// sequenced ALU controller (slave).
interface alu_seq_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_op;
    logic [1:0] in_rd;
    logic [1:0] in_ra;
    logic [1:0] in_rb;
    logic       in_use_imm;
    logic [3:0] in_imm;

    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic       out_zero;
    logic       out_carry;
    logic       out_overflow;
    logic       out_error;
    logic [7:0] err_count;

    modport master (
        output in_valid, in_op, in_rd, in_ra, in_rb, in_use_imm, in_imm, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_carry, out_overflow,
               out_error, err_count
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_ra, in_rb, in_use_imm, in_imm, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_carry, out_overflow,
               out_error, err_count
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequenced 4-bit ALU controller: R0..R3 register file, HI/LO, shift-add multiply,
// one combinational ALU, valid/ready on both the instruction and result sides.
package alu_seq_pkg;
    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_AND    = 4'h2;
    localparam logic [3:0] OP_OR     = 4'h3;
    localparam logic [3:0] OP_XOR    = 4'h4;
    localparam logic [3:0] OP_ROL    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_DIVIDE = 4'h7;
    localparam logic [3:0] OP_MULT   = 4'h8;
    localparam logic [3:0] OP_MFHI   = 4'h9;
    localparam logic [3:0] OP_MFLO   = 4'hA;
endpackage

module alu_core
    import alu_seq_pkg::*;
(
    input  logic [3:0] op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] result,
    output logic       zero,
    output logic       carry,
    output logic       overflow,
    output logic       error
);
    logic [4:0] wide;
    logic [7:0] dbl;

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        result   = 4'd0;
        carry    = 1'b0;
        overflow = 1'b0;
        error    = 1'b0;
        wide     = 5'd0;
        dbl      = 8'd0;
        case (op)
            OP_ADD: begin
                wide     = {1'b0, a} + {1'b0, b};
                result   = wide[3:0];
                carry    = wide[4];
                overflow = (a[3] == b[3]) && (wide[3] != a[3]);
            end
            OP_SUB: begin
                wide     = {1'b0, a} - {1'b0, b};
                result   = wide[3:0];
                carry    = wide[4];
                overflow = (a[3] != b[3]) && (wide[3] != a[3]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_ROL: begin
                dbl = {a, a} << b[1:0];
                if (b > 4'd3) begin
                    error  = 1'b1;
                    result = a;
                end else begin
                    result = dbl[7:4];
                end
            end
            OP_ROR: begin
                dbl = {a, a} >> b[1:0];
                if (b > 4'd3) begin
                    error  = 1'b1;
                    result = a;
                end else begin
                    result = dbl[3:0];
                end
            end
            OP_DIVIDE: begin
                if (b == 4'd0) error  = 1'b1;
                else           result = a / b;
            end
            OP_MULT, OP_MFHI, OP_MFLO: result = 4'd0;
            default: error = 1'b1;
        endcase
        zero = (result == 4'd0);
    end
endmodule

module alu_seq_ctrl
    import alu_seq_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    alu_seq_ctrl_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0] state;
    logic [3:0] rf [4];
    logic [3:0] hi, lo;
    logic [3:0] op_q, a_q, b_q;
    logic [1:0] rd_q;
    logic [7:0] mul_acc;
    logic [1:0] mul_cnt;

    logic       out_valid_q;
    logic [3:0] out_result_q;
    logic       zero_q, carry_q, overflow_q, error_q;
    logic [7:0] err_count_q;

    logic [3:0] src_a, src_b;
    logic [3:0] alu_result;
    logic       alu_zero, alu_carry, alu_overflow, alu_error;
    logic [7:0] partial, acc_next;
    logic [3:0] exec_result;
    logic       exec_zero, exec_carry, exec_overflow, exec_error;
    logic       exec_done;

    assign src_a = (bus.in_ra == 2'd0) ? 4'd0 : rf[bus.in_ra];
    assign src_b = bus.in_use_imm ? bus.in_imm
                 : ((bus.in_rb == 2'd0) ? 4'd0 : rf[bus.in_rb]);

    alu_core u_alu (
        .op       (op_q),
        .a        (a_q),
        .b        (b_q),
        .result   (alu_result),
        .zero     (alu_zero),
        .carry    (alu_carry),
        .overflow (alu_overflow),
        .error    (alu_error)
    );

    // One multiplier bit per EXEC cycle, LSB first; the last step is consumed directly.
    assign partial  = b_q[mul_cnt] ? ({4'd0, a_q} << mul_cnt) : 8'd0;
    assign acc_next = mul_acc + partial;
    assign exec_done = (op_q != OP_MULT) || (mul_cnt == 2'd3);

    always_comb begin
        exec_result   = alu_result;
        exec_zero     = alu_zero;
        exec_carry    = alu_carry;
        exec_overflow = alu_overflow;
        exec_error    = alu_error;
        if (op_q == OP_MULT || op_q == OP_MFHI || op_q == OP_MFLO) begin
            exec_carry    = 1'b0;
            exec_overflow = 1'b0;
            exec_error    = 1'b0;
            case (op_q)
                OP_MULT: exec_result = acc_next[3:0];
                OP_MFHI: exec_result = hi;
                default: exec_result = lo;
            endcase
            exec_zero = (op_q == OP_MULT) ? (acc_next == 8'd0) : (exec_result == 4'd0);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            // NOTE: the tiny register file is reset explicitly because R1..R3 must read 0 after reset.
            for (int i = 0; i < 4; i++) rf[i] <= 4'd0;
            hi           <= 4'd0;
            lo           <= 4'd0;
            op_q         <= 4'd0;
            a_q          <= 4'd0;
            b_q          <= 4'd0;
            rd_q         <= 2'd0;
            mul_acc      <= 8'd0;
            mul_cnt      <= 2'd0;
            out_valid_q  <= 1'b0;
            out_result_q <= 4'd0;
            zero_q       <= 1'b0;
            carry_q      <= 1'b0;
            overflow_q   <= 1'b0;
            error_q      <= 1'b0;
            err_count_q  <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        op_q    <= bus.in_op;
                        rd_q    <= bus.in_rd;
                        a_q     <= src_a;
                        b_q     <= src_b;
                        mul_acc <= 8'd0;
                        mul_cnt <= 2'd0;
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (op_q == OP_MULT) begin
                        mul_acc <= acc_next;
                        mul_cnt <= mul_cnt + 2'd1;
                    end
                    if (exec_done) begin
                        if (rd_q != 2'd0) rf[rd_q] <= exec_result;
                        if (op_q == OP_MULT) begin
                            lo <= acc_next[3:0];
                            hi <= acc_next[7:4];
                        end
                        out_result_q <= exec_result;
                        zero_q       <= exec_zero;
                        carry_q      <= exec_carry;
                        overflow_q   <= exec_overflow;
                        error_q      <= exec_error;
                        if (exec_error && err_count_q != 8'hFF)
                            err_count_q <= err_count_q + 8'd1;
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // out_valid rises one cycle after the result registers settle.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready     = (state == ST_IDLE);
    assign bus.out_valid    = out_valid_q;
    assign bus.out_result   = out_result_q;
    assign bus.out_zero     = zero_q;
    assign bus.out_carry    = carry_q;
    assign bus.out_overflow = overflow_q;
    assign bus.out_error    = error_q;
    assign bus.err_count    = err_count_q;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: hand-computed results, flags, latencies,
// back-pressure, reset abort and error-counter saturation.
module tb_alu_seq_ctrl;
    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_AND    = 4'h2;
    localparam logic [3:0] OP_OR     = 4'h3;
    localparam logic [3:0] OP_XOR    = 4'h4;
    localparam logic [3:0] OP_ROL    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_DIVIDE = 4'h7;
    localparam logic [3:0] OP_MULT   = 4'h8;
    localparam logic [3:0] OP_MFHI   = 4'h9;
    localparam logic [3:0] OP_MFLO   = 4'hA;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   lat;
    logic [3:0] res;
    logic [3:0] fl;
    bit   saw_valid;

    alu_seq_ctrl_if bus ();

    alu_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one instruction, wait (bounded) for the result, then accept it.
    task automatic run_op(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                          input logic [1:0] rb, input logic use_imm, input logic [3:0] imm,
                          output int lat_o, output logic [3:0] res_o, output logic [3:0] fl_o);
        bus.in_op      = op;
        bus.in_rd      = rd;
        bus.in_ra      = ra;
        bus.in_rb      = rb;
        bus.in_use_imm = use_imm;
        bus.in_imm     = imm;
        bus.in_valid   = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat_o = 0;
        while (bus.out_valid !== 1'b1 && lat_o < 20) begin
            @(posedge clk); #1;
            lat_o++;
        end
        res_o = bus.out_result;
        fl_o  = {bus.out_zero, bus.out_carry, bus.out_overflow, bus.out_error};
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    // Flags packed as {zero, carry, overflow, error}.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [1:0] rd,
                         input logic [1:0] ra, input logic [1:0] rb, input logic use_imm,
                         input logic [3:0] imm, input int exp_lat, input int exp_res,
                         input int exp_fl);
        int         l;
        logic [3:0] r;
        logic [3:0] f;
        run_op(op, rd, ra, rb, use_imm, imm, l, r, f);
        check({tag, " latency"}, 32'(l), 32'(exp_lat));
        check({tag, " result"},  32'(r), 32'(exp_res));
        check({tag, " flags"},   32'(f), 32'(exp_fl));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bus.in_valid   = 1'b0;
        bus.in_op      = 4'd0;
        bus.in_rd      = 2'd0;
        bus.in_ra      = 2'd0;
        bus.in_rb      = 2'd0;
        bus.in_use_imm = 1'b0;
        bus.in_imm     = 4'd0;
        bus.out_ready  = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", 32'(bus.out_valid), 0);
        check("reset out_result", 32'(bus.out_result), 0);
        check("reset flags", 32'({bus.out_zero, bus.out_carry, bus.out_overflow, bus.out_error}), 0);
        check("reset err_count", 32'(bus.err_count), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("in_ready after reset", 32'(bus.in_ready), 1);

        do_op("add r1=0+7",   OP_ADD,  2'd1, 2'd0, 2'd0, 1'b1, 4'd7,  2, 'h7, 'b0000);
        do_op("add r2=r1+10", OP_ADD,  2'd2, 2'd1, 2'd0, 1'b1, 4'd10, 2, 'h1, 'b0100);
        do_op("mult 7*9",     OP_MULT, 2'd0, 2'd1, 2'd0, 1'b1, 4'd9,  5, 'hF, 'b0000);
        do_op("mflo",         OP_MFLO, 2'd0, 2'd0, 2'd0, 1'b0, 4'd0,  2, 'hF, 'b0000);
        do_op("mfhi r3",      OP_MFHI, 2'd3, 2'd0, 2'd0, 1'b0, 4'd0,  2, 'h3, 'b0000);
        do_op("read r3",      OP_OR,   2'd0, 2'd3, 2'd0, 1'b1, 4'd0,  2, 'h3, 'b0000);
        do_op("sub r1-r2",    OP_SUB,  2'd0, 2'd1, 2'd2, 1'b0, 4'd0,  2, 'h6, 'b0000);
        do_op("sub r2-r1",    OP_SUB,  2'd0, 2'd2, 2'd1, 1'b0, 4'd0,  2, 'hA, 'b0100);
        do_op("add overflow", OP_ADD,  2'd0, 2'd1, 2'd0, 1'b1, 4'd1,  2, 'h8, 'b0010);
        do_op("and",          OP_AND,  2'd0, 2'd1, 2'd0, 1'b1, 4'd3,  2, 'h3, 'b0000);
        do_op("xor",          OP_XOR,  2'd0, 2'd1, 2'd0, 1'b1, 4'hF,  2, 'h8, 'b0000);
        do_op("div by zero",  OP_DIVIDE, 2'd0, 2'd1, 2'd0, 1'b1, 4'd0, 2, 'h0, 'b1001);
        check("err_count after div0", 32'(bus.err_count), 1);
        do_op("div 7/2",      OP_DIVIDE, 2'd0, 2'd1, 2'd0, 1'b1, 4'd2, 2, 'h3, 'b0000);
        do_op("rol 1",        OP_ROL,  2'd0, 2'd1, 2'd0, 1'b1, 4'd1,  2, 'hE, 'b0000);
        do_op("ror 1",        OP_ROR,  2'd0, 2'd1, 2'd0, 1'b1, 4'd1,  2, 'hB, 'b0000);
        do_op("rol 5 error",  OP_ROL,  2'd0, 2'd1, 2'd0, 1'b1, 4'd5,  2, 'h7, 'b0001);
        check("err_count after rol", 32'(bus.err_count), 2);
        do_op("hi unchanged", OP_MFHI, 2'd0, 2'd0, 2'd0, 1'b0, 4'd0,  2, 'h3, 'b0000);
        do_op("add r0=5",     OP_ADD,  2'd0, 2'd0, 2'd0, 1'b1, 4'd5,  2, 'h5, 'b0000);
        do_op("read r0",      OP_OR,   2'd0, 2'd0, 2'd0, 1'b1, 4'd0,  2, 'h0, 'b1000);

        // Back-pressure: result held, a pending instruction must not be taken.
        bus.in_op = OP_ADD; bus.in_rd = 2'd0; bus.in_ra = 2'd1; bus.in_use_imm = 1'b1;
        bus.in_imm = 4'd1; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_op = OP_ADD; bus.in_rd = 2'd1; bus.in_ra = 2'd0; bus.in_imm = 4'd9;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("stall latency", 32'(lat), 2);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("stall out_valid", 32'(bus.out_valid), 1);
            check("stall out_result", 32'(bus.out_result), 'h8);
            check("stall in_ready", 32'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("release out_valid", 32'(bus.out_valid), 0);
        check("release in_ready", 32'(bus.in_ready), 1);
        repeat (3) @(posedge clk);
        #1;
        check("no extra accept", 32'(bus.in_ready), 1);
        do_op("r1 untouched", OP_OR, 2'd0, 2'd1, 2'd0, 1'b1, 4'd0, 2, 'h7, 'b0000);

        // Reset in the third EXEC cycle of a multiply aborts it.
        bus.in_op = OP_MULT; bus.in_rd = 2'd1; bus.in_ra = 2'd1; bus.in_use_imm = 1'b1;
        bus.in_imm = 4'd9; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        check("rst in_ready", 32'(bus.in_ready), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) saw_valid = 1'b1;
        end
        check("aborted mult no valid", 32'(saw_valid), 0);
        check("in_ready after abort", 32'(bus.in_ready), 1);
        check("err_count after abort", 32'(bus.err_count), 0);
        do_op("hi after abort", OP_MFHI, 2'd0, 2'd0, 2'd0, 1'b0, 4'd0, 2, 'h0, 'b1000);
        do_op("lo after abort", OP_MFLO, 2'd0, 2'd0, 2'd0, 1'b0, 4'd0, 2, 'h0, 'b1000);
        do_op("r1 after abort", OP_OR,   2'd0, 2'd1, 2'd0, 1'b1, 4'd0, 2, 'h0, 'b1000);

        // Error counter saturation.
        for (int i = 0; i < 254; i++)
            run_op(OP_DIVIDE, 2'd0, 2'd1, 2'd0, 1'b1, 4'd0, lat, res, fl);
        check("err_count 254", 32'(bus.err_count), 254);
        run_op(OP_DIVIDE, 2'd0, 2'd1, 2'd0, 1'b1, 4'd0, lat, res, fl);
        check("err_count 255", 32'(bus.err_count), 255);
        run_op(OP_DIVIDE, 2'd0, 2'd1, 2'd0, 1'b1, 4'd0, lat, res, fl);
        check("err_count saturated", 32'(bus.err_count), 255);
        check("sat div result", 32'({res, fl}), 'h09);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
